dpp_table: RTL and testbench
============================

Name: dpp_table

Overview:
- Central fork arbiter for the dining-philosophers design, at the other end of the philosopher event interface.
- Collects hungry and done notifications from N philosopher blocks and owns the N forks.
- Issues one-cycle eat events to philosophers. Each eat bit drives that philosopher's event_in[`EAT_SIG].
- Guarantees no fork is held by two philosophers and that hungry philosophers are served fairly in round-robin order.

Parameters:
- N_PHILO, 5, number of philosophers and forks (range 3..8).
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W >= N_PHILO.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- hungry  input  N_PHILO  one-cycle pulse per philosopher: philosopher n became hungry.
- done  input  N_PHILO  one-cycle pulse per philosopher: philosopher n finished eating.
- eat  output  N_PHILO  registered one-cycle grant pulse to philosopher n.
- eating  output  N_PHILO  registered level: philosopher n currently holds both forks.
- fork_busy  output  N_PHILO  registered level: fork f is held.
- proto_err  output  1  sticky registered protocol-error flag.

Behaviour:
- Fork mapping:
  - Philosopher n uses fork n and fork (n+1) mod N_PHILO.
  - Fork f is shared by philosophers f and (f-1) mod N_PHILO.
  - Invariant: fork_busy[f] == eating[f] | eating[(f-1) mod N] on every cycle.
- Internal state:
  - hungry_q[N]: pending requests.
  - eating[N].
  - fork_busy[N].
  - ptr (PTR_W bits): next philosopher to consider.
  - proto_err.
- Reset values (asynchronous): eat=0, eating=0, fork_busy=0, hungry_q=0, ptr=0, proto_err=0. Reset mid-operation drops all pending requests and frees all forks immediately.
- Request capture:
  - A hungry[n] pulse sampled at edge t sets hungry_q[n] at edge t.
  - If eating[n] or hungry_q[n] is already set, the pulse is ignored and proto_err is set.
- Release:
  - A done[n] pulse sampled at edge t with eating[n]=1 clears eating[n] and both of its forks at edge t.
  - A done[n] with eating[n]=0 is ignored and sets proto_err.
- Grant evaluation:
  - Combinational on registered state every cycle.
  - Search from ptr upward, wrapping N-1 -> 0.
  - The winner is the first n with hungry_q[n]=1, fork_busy[n]=0 and fork_busy[(n+1) mod N]=0.
  - At most one grant per cycle.
  - On a grant at edge t+1: eat[n]=1 for exactly one cycle, eating[n]=1, both forks busy, hungry_q[n]=0, ptr=(n+1) mod N.
  - With no winner, ptr holds and eat=0.
- Latency:
  - A hungry pulse at edge t with free forks gives eat high after edge t+1 (2 edges, request to grant).
  - Forks freed by done at edge t are grantable at edge t+1.
- Simultaneous events:
  - hungry[n] and done[n] in the same cycle on an eating philosopher: done is processed, the request is captured, and no proto_err is raised.
  - A grant and a done on a neighbour in the same edge are independent. The grant uses pre-edge fork state, so the forks the done is releasing cannot be granted in that same edge.
  - A hungry pulse arriving at the same edge a grant is computed is not eligible until the next evaluation.
- proto_err clears only on reset.
- Capacity: with N_PHILO=5, at most 2 philosophers eat concurrently. No two adjacent philosophers ever eat.

Test Plan:
- Reset, then idle 10 cycles -> eat, eating, fork_busy all 0; proto_err=0.
- hungry[0] pulse at edge 1 -> eat=00001 after edge 2; eating=00001; fork_busy=00011; ptr=1.
- hungry=11111 single pulse -> grants in order: eat[0] after edge 2, eat[2] after edge 3; then no further grants; eating=00101; fork_busy=01111. Then done[0] -> eat[1] is not granted, because fork 2 is still held by philosopher 2; eat[4] is granted the next edge; ptr wraps to 0.
- Philosopher 1 eating, done[1] and hungry[2] pulsed in the same cycle -> eat[2] one edge after the forks free; fork_busy never shows fork 2 double-owned.
- done[3] while not eating, then hungry[0] while eating[0]=1 -> proto_err=1 after the first; both ignored; state unchanged.
- Fairness and reset mid-operation:
  - Philosophers 0 and 2 repeatedly hungry/done with philosopher 1 hungry -> philosopher 1 is served within 2 grant opportunities once forks 1 and 2 are free.
  - Assert reset while eating=00101 -> all outputs 0 asynchronously; the first post-reset hungry[4] is granted after 2 edges.

Source files
------------

// File: rtl/dpp_table.sv
`default_nettype none
// ============================================================================
// Module   : dpp_table
// Function : Round-robin fork arbiter for N dining philosophers.
// Revision : 1.0 - initial release
// ============================================================================
module dpp_table #(
    parameter int N_PHILO = 5,
    parameter int PTR_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHILO-1:0] hungry,
    input  logic [N_PHILO-1:0] done,
    output logic [N_PHILO-1:0] eat,
    output logic [N_PHILO-1:0] eating,
    output logic [N_PHILO-1:0] fork_busy,
    output logic               proto_err
);

    logic [N_PHILO-1:0] r_eat;
    logic [N_PHILO-1:0] r_eating;
    logic [N_PHILO-1:0] r_fork_busy;
    logic [N_PHILO-1:0] r_hungry_q;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_proto_err;

    logic [N_PHILO-1:0] w_elig;
    logic [N_PHILO-1:0] w_win;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_found;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [N_PHILO-1:0] w_done_ok;
    logic [N_PHILO-1:0] w_capture;
    logic               w_err;
    logic [N_PHILO-1:0] w_eating_next;
    logic [N_PHILO-1:0] w_hq_next;
    logic [N_PHILO-1:0] w_fork_next;

    // A same-cycle done lets an eating philosopher queue its next request legally.
    assign w_done_ok     = done & r_eating;
    assign w_capture     = hungry & ~r_hungry_q & (~r_eating | done);
    assign w_err         = (|(hungry & ~w_capture)) | (|(done & ~r_eating));
    assign w_eating_next = (r_eating & ~w_done_ok) | w_win;
    assign w_hq_next     = (r_hungry_q & ~w_win) | w_capture;
    assign w_ptr_next    = (w_win_idx == PTR_W'(N_PHILO - 1)) ? '0 : w_win_idx + 1'b1;

    for (genvar n = 0; n < N_PHILO; n++) begin : g_philo
        localparam int c_nxt = (n + 1) % N_PHILO;
        localparam int c_prv = (n + N_PHILO - 1) % N_PHILO;
        assign w_elig[n]      = r_hungry_q[n] & ~r_fork_busy[n] & ~r_fork_busy[c_nxt];
        assign w_fork_next[n] = w_eating_next[n] | w_eating_next[c_prv];
    end

    // Eligibility uses pre-edge fork state, so forks released this edge wait a cycle.
    always_comb begin
        int idx;
        w_win     = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_PHILO; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= N_PHILO) idx = idx - N_PHILO;
            if (!w_found && w_elig[idx]) begin
                w_found      = 1'b1;
                w_win[idx]   = 1'b1;
                w_win_idx    = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eat       <= '0;
            r_eating    <= '0;
            r_fork_busy <= '0;
            r_hungry_q  <= '0;
            r_ptr       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_eat       <= w_win;
            r_eating    <= w_eating_next;
            r_fork_busy <= w_fork_next;
            r_hungry_q  <= w_hq_next;
            if (w_found) r_ptr <= w_ptr_next;
            r_proto_err <= r_proto_err | w_err;
        end
    end

    assign eat       = r_eat;
    assign eating    = r_eating;
    assign fork_busy = r_fork_busy;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_dpp_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpp_table
// Function : Directed and random checks of dpp_table against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpp_table;

    localparam int N = 5;

    logic         clk;
    logic         reset;
    logic [N-1:0] hungry;
    logic [N-1:0] done;
    logic [N-1:0] eat;
    logic [N-1:0] eating;
    logic [N-1:0] fork_busy;
    logic         proto_err;

    int n_vec;
    int n_err;

    // Reference model state
    int       m_hq  [N];
    int       m_eat [N];
    int       m_ptr;
    bit       m_err;
    bit [N-1:0] m_pulse;

    dpp_table #(.N_PHILO(N), .PTR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .hungry    (hungry),
        .done      (done),
        .eat       (eat),
        .eating    (eating),
        .fork_busy (fork_busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_fork(input int f);
        return (m_eat[f] != 0) || (m_eat[(f + N - 1) % N] != 0);
    endfunction

    function automatic bit [N-1:0] pack_eat();
        bit [N-1:0] v = '0;
        for (int n = 0; n < N; n++) v[n] = (m_eat[n] != 0);
        return v;
    endfunction

    function automatic bit [N-1:0] pack_fork();
        bit [N-1:0] v = '0;
        for (int f = 0; f < N; f++) v[f] = m_fork(f);
        return v;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            m_hq[n]  = 0;
            m_eat[n] = 0;
        end
        m_ptr   = 0;
        m_err   = 0;
        m_pulse = '0;
    endfunction

    function automatic void model_step(input bit [N-1:0] h, input bit [N-1:0] d);
        int w = -1;
        for (int i = 0; i < N; i++) begin
            int c = (m_ptr + i) % N;
            if (w < 0 && m_hq[c] != 0 && !m_fork(c) && !m_fork((c + 1) % N)) w = c;
        end
        for (int n = 0; n < N; n++) begin
            if (h[n]) begin
                if (m_hq[n] != 0 || (m_eat[n] != 0 && !d[n])) m_err = 1;
                else m_hq[n] = 1;
            end
            if (d[n]) begin
                if (m_eat[n] != 0) m_eat[n] = 0;
                else m_err = 1;
            end
        end
        m_pulse = '0;
        if (w >= 0) begin
            m_eat[w]   = 1;
            m_hq[w]    = 0;
            m_ptr      = (w + 1) % N;
            m_pulse[w] = 1'b1;
        end
    endfunction

    task automatic check_all(input string where);
        bit [N-1:0] e;
        e = pack_eat();
        chk({where, ".eat"},       32'(eat),       32'(m_pulse));
        chk({where, ".eating"},    32'(eating),    32'(e));
        chk({where, ".fork_busy"}, 32'(fork_busy), 32'(pack_fork()));
        chk({where, ".proto_err"}, 32'(proto_err), 32'(m_err));
        chk({where, ".adjacent"},  32'((eating & {eating[0], eating[N-1:1]}) != '0), 32'(0));
    endtask

    task automatic step(input logic [N-1:0] h, input logic [N-1:0] d);
        @(negedge clk);
        hungry = h;
        done   = d;
        @(posedge clk);
        model_step(h, d);
        #1;
        check_all("step");
        hungry = '0;
        done   = '0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("rst.eat",       32'(eat),       32'(0));
        chk("rst.eating",    32'(eating),    32'(0));
        chk("rst.fork_busy", 32'(fork_busy), 32'(0));
        chk("rst.proto_err", 32'(proto_err), 32'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] h;
        logic [N-1:0] d;
        n_vec  = 0;
        n_err  = 0;
        hungry = '0;
        done   = '0;
        reset  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        async_reset();
        repeat (10) step('0, '0);

        // Single request: grant two edges after the pulse
        step(5'b00001, '0);
        step('0, '0);
        chk("single.eat",  32'(eat),       32'(5'b00001));
        chk("single.fork", 32'(fork_busy), 32'(5'b00011));

        // All hungry at once
        async_reset();
        step(5'b11111, '0);
        step('0, '0);
        chk("all.eat0", 32'(eat), 32'(5'b00001));
        step('0, '0);
        chk("all.eat2",   32'(eat),       32'(5'b00100));
        chk("all.eating", 32'(eating),    32'(5'b00101));
        chk("all.fork",   32'(fork_busy), 32'(5'b01111));
        step('0, '0);
        chk("all.none", 32'(eat), 32'(0));
        step('0, 5'b00001);
        step('0, '0);
        chk("all.eat4", 32'(eat), 32'(5'b10000));

        // Reset while eating, then first request after reset
        async_reset();
        step(5'b00101, '0);
        step('0, '0);
        step('0, '0);
        chk("pre_rst.eating", 32'(eating), 32'(5'b00101));
        async_reset();
        step(5'b10000, '0);
        step('0, '0);
        chk("post_rst.eat", 32'(eat), 32'(5'b10000));

        // done and hungry together on a neighbour
        async_reset();
        step(5'b00010, '0);
        step('0, '0);
        step(5'b00100, 5'b00010);
        step('0, '0);
        chk("nbr.eat2",  32'(eat),       32'(5'b00100));
        chk("nbr.error", 32'(proto_err), 32'(0));

        // Fairness: philosopher 1 wins once its forks free
        async_reset();
        step(5'b00101, '0);
        step('0, '0);
        step('0, '0);
        step(5'b00010, '0);
        step('0, 5'b00101);
        step(5'b00101, '0);
        chk("fair.eat1", 32'(eat), 32'(5'b00010));

        // Protocol errors
        async_reset();
        step('0, 5'b01000);
        chk("err.done", 32'(proto_err), 32'(1));
        step(5'b00001, '0);
        step('0, '0);
        step(5'b00001, '0);
        chk("err.eating", 32'(eating), 32'(5'b00001));

        // Randomized traffic, mostly legal, with occasional errors and resets
        async_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                h = '0;
                d = '0;
                for (int n = 0; n < N; n++) begin
                    if (m_hq[n] == 0 && m_eat[n] == 0) h[n] = ($urandom_range(0, 5) == 0);
                    else h[n] = ($urandom_range(0, 199) == 0);
                    if (m_eat[n] != 0) d[n] = ($urandom_range(0, 3) == 0);
                    else d[n] = ($urandom_range(0, 299) == 0);
                end
                step(h, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
